// File: rtl/blk4x4_gather16x16_pkg.sv
// Shared constants, state encoding and the 4x4 sub-block to 16x16 raster
// offset used by both the gather writer and the distortion slicer.
package blk4x4_gather16x16_pkg;

    localparam int PIX_W   = 8;
    localparam int BLK_N   = 16;
    localparam int SUB_N   = 4;
    localparam int NUM_SUB = (BLK_N / SUB_N) * (BLK_N / SUB_N);
    localparam int SUB_PIX = SUB_N * SUB_N;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    // Raster pixel index of the top-left pixel of sub-block k.
    function automatic int blk_off(input int k);
        return (BLK_N * SUB_N) * (k / SUB_N) + SUB_N * (k % SUB_N);
    endfunction

endpackage

// File: rtl/blk4x4_gather16x16_if.sv
// Sub-block input stream plus assembled 16x16 block output.
interface blk4x4_gather16x16_if #(
    parameter int BW = 8
);
    logic               start;
    logic               in_valid;
    logic               in_ready;
    logic [16*BW-1:0]   in_data;
    logic [256*BW-1:0]  out;
    logic               done;
    logic               busy;
    logic               err;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, out, done, busy, err
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, out, done, busy, err
    );
endinterface

// File: rtl/blk4x4_gather16x16.sv
// Reassembles sixteen serial 4x4 sub-blocks into one 16x16 raster block.
// Beat k writes its 16 bytes straight into the matching byte lanes of out.
module blk4x4_gather16x16
    import blk4x4_gather16x16_pkg::*;
#(
    parameter int BIT_WIDTH  = PIX_W,
    parameter int BLOCK_SIZE = BLK_N
) (
    input  logic                clk,
    input  logic                rst,
    blk4x4_gather16x16_if.slave bus
);

    localparam int OUT_W = BIT_WIDTH * BLOCK_SIZE * BLOCK_SIZE;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic               accept;
    logic [NUM_SUB-1:0] lane_we;

    assign bus.in_ready = (state_q == ST_FILL) & ~bus.start;
    assign accept       = bus.in_valid & bus.in_ready;

    // One enable per sub-block; only the addressed 16 bytes change per beat.
    for (genvar gk = 0; gk < NUM_SUB; gk++) begin : g_sub
        assign lane_we[gk] = accept & (cnt_q == 4'(gk));
        for (genvar gp = 0; gp < SUB_PIX; gp++) begin : g_pix
            localparam int DST = blk_off(gk) + BLOCK_SIZE * (gp / SUB_N) + (gp % SUB_N);
            assign out_d[BIT_WIDTH*DST +: BIT_WIDTH] =
                bus.start   ? '0 :
                lane_we[gk] ? bus.in_data[BIT_WIDTH*gp +: BIT_WIDTH] :
                              out_q[BIT_WIDTH*DST +: BIT_WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = err_q;
        if (bus.start) begin
            state_d = ST_FILL;
            cnt_d   = 4'd0;
            err_d   = 1'b0;
        end else begin
            if (bus.in_valid & ~bus.in_ready) begin
                err_d = 1'b1;
            end
            if (accept) begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = ST_FULL;
                    done_d  = 1'b1;
                end
            end
        end
        busy_d = (state_d == ST_FILL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            out_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_blk4x4_gather16x16.sv
// Directed bench for the 4x4 -> 16x16 gather block with a behavioural model
// and a queue of expected completed blocks.
module tb_blk4x4_gather16x16;

    localparam int M_IDLE = 0;
    localparam int M_FILL = 1;
    localparam int M_FULL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    blk4x4_gather16x16_if #(.BW(8)) bus ();

    blk4x4_gather16x16 #(.BIT_WIDTH(8), .BLOCK_SIZE(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    int           m_state = M_IDLE;
    int           m_cnt   = 0;
    logic [2047:0] m_out  = '0;
    logic         m_done  = 1'b0;
    logic         m_err   = 1'b0;
    logic [2047:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_blk(input string tag, input logic [2047:0] obs, input logic [2047:0] exp);
        int idx;
        idx = 0;
        total++;
        assert (obs === exp) else begin
            bad++;
            for (int i = 255; i >= 0; i--) if (obs[8*i +: 8] !== exp[8*i +: 8]) idx = i;
            $error("FAIL %s byte(r=%0d,c=%0d) observed=%0h expected=%0h",
                   tag, idx / 16, idx % 16, obs[8*idx +: 8], exp[8*idx +: 8]);
        end
    endtask

    function automatic logic [127:0] pat_const(input int k);
        logic [127:0] d;
        for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(k);
        return d;
    endfunction

    function automatic logic [127:0] pat_idx(input int k);
        logic [127:0] d;
        for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(16 * k + i);
        return d;
    endfunction

    // Advance the model by the inputs now applied, clock once, then check.
    task automatic tick();
        logic acc;
        int   k;
        acc    = bus.in_valid && (m_state == M_FILL) && !bus.start;
        m_done = 1'b0;
        if (bus.start) begin
            m_state = M_FILL;
            m_cnt   = 0;
            m_out   = '0;
            m_err   = 1'b0;
        end else begin
            if (bus.in_valid && !acc) m_err = 1'b1;
            if (acc) begin
                k = m_cnt;
                for (int y = 0; y < 4; y++)
                    for (int x = 0; x < 4; x++)
                        m_out[8*(16*(4*(k/4)+y) + 4*(k%4)+x) +: 8] = bus.in_data[8*(4*y+x) +: 8];
                if (m_cnt == 15) begin
                    m_state = M_FULL;
                    m_done  = 1'b1;
                    exp_q.push_back(m_out);
                end
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        chk("done", 64'(bus.done), 64'(m_done));
        chk("busy", 64'(bus.busy), 64'(m_state == M_FILL));
        chk("err", 64'(bus.err), 64'(m_err));
        chk("in_ready", 64'(bus.in_ready), 64'((m_state == M_FILL) && !bus.start));
        if (bus.done === 1'b1 && exp_q.size() > 0) chk_blk("done_block", bus.out, exp_q.pop_front());
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic beat(input logic [127:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_cnt   = 0;
        m_out   = '0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        exp_q.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk_blk({tag, "_out"}, bus.out, '0);
        chk({tag, "_done"}, 64'(bus.done), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_err"}, 64'(bus.err), 64'd0);
        chk({tag, "_ready"}, 64'(bus.in_ready), 64'd0);
    endtask

    initial begin
        logic [2047:0] ref_blk;
        logic [2047:0] saved;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // Reset state
        #12;
        chk_all_zero("reset");
        rst = 1'b0;

        // Back-to-back block, every byte of beat k equal to k
        pulse_start();
        for (int k = 0; k < 16; k++) beat(pat_const(k));
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) ref_blk[8*(16*r+c) +: 8] = 8'(4*(r/4) + c/4);
        chk_blk("const_block", bus.out, ref_blk);
        tick();
        chk("const_busy_after", 64'(bus.busy), 64'd0);
        chk("const_err_after", 64'(bus.err), 64'd0);

        // Indexed pattern with in_valid toggled every other cycle
        pulse_start();
        for (int k = 0; k < 16; k++) begin
            beat(pat_idx(k));
            if (k != 15) tick();
        end
        for (int k = 0; k < 16; k++)
            for (int y = 0; y < 4; y++)
                for (int x = 0; x < 4; x++)
                    ref_blk[8*(16*(4*(k/4)+y) + 4*(k%4)+x) +: 8] = 8'(16*k + 4*y + x);
        chk_blk("idx_block", bus.out, ref_blk);
        tick();

        // Beat offered while FULL: ignored, err set
        saved = bus.out;
        beat(pat_const(8'hAA));
        chk_blk("full_hold", bus.out, saved);
        chk("full_err", 64'(bus.err), 64'd1);
        tick();

        // Beat offered while IDLE: ignored, err set and sticky until start
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        model_reset();
        beat(pat_const(8'h55));
        chk_blk("idle_hold", bus.out, '0);
        tick();
        tick();
        chk("idle_err_sticky", 64'(bus.err), 64'd1);
        pulse_start();
        chk("err_cleared", 64'(bus.err), 64'd0);

        // start collides with beat-15 handshake: start wins
        for (int k = 0; k < 15; k++) beat(pat_idx(k));
        bus.start = 1'b1;
        beat(pat_idx(15));
        bus.start = 1'b0;
        chk("collide_done", 64'(bus.done), 64'd0);
        chk("collide_busy", 64'(bus.busy), 64'd1);
        chk_blk("collide_out", bus.out, '0);
        for (int k = 0; k < 16; k++) beat(pat_idx(k));
        chk_blk("collide_refill", bus.out, ref_blk);
        tick();

        // Asynchronous reset after 7 beats
        pulse_start();
        for (int k = 0; k < 7; k++) beat(pat_const(k + 1));
        rst = 1'b1;
        #2;
        chk_all_zero("midreset");
        rst = 1'b0;
        model_reset();
        tick();
        pulse_start();
        for (int k = 0; k < 16; k++) beat(pat_idx(k));
        chk_blk("post_reset_block", bus.out, ref_blk);
        tick();

        // start while FULL with no beats clears out
        pulse_start();
        chk_blk("restart_clear", bus.out, '0);
        chk("restart_done", 64'(bus.done), 64'd0);
        tick();
        tick();
        chk("restart_done_late", 64'(bus.done), 64'd0);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/blk4x4_gather16x16.md
# blk4x4_gather16x16

Collects sixteen 4x4 pixel sub-blocks arriving serially on a valid/ready stream and reassembles them into one 16x16 raster block. It is the writer-side counterpart of the 16x16 distortion path, which slices a raster block into 4x4 sub-blocks for the 4x4 engine. It sits after any 4x4-granular stage, such as prediction or reconstruction, and produces a 16x16 block in the same packing the distortion and prediction modules consume.

## Interface
- BIT_WIDTH, 8: pixel width in bits.
- BLOCK_SIZE, 16: output block edge in pixels; only 16 is supported.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a new block.
- in_valid  in  1  sub-block beat present.
- in_ready  out  1  block accepts a beat; combinational.
- in_data  in  8*16  one 4x4 sub-block; pixel (y,x) at bits [8*(4y+x) +: 8].
- out  out  8*256  16x16 block; pixel (r,c) at bits [8*(16r+c) +: 8].
- done  out  1  one-cycle pulse when `out` is complete.
- busy  out  1  high while the block is filling.
- err  out  1  sticky flag: a beat was offered while `in_ready` was 0.

## Operation
- States:
  - IDLE: reset state.
  - FILL: accepting beats.
  - FULL: block complete, `out` held.
- Beat acceptance:
  - A beat is accepted when `in_valid & in_ready`.
  - `in_ready = (state == FILL) & ~start`.
- Sub-block order:
  - Beat k (0..15) is written to raster position row-of-blocks k/4, column-of-blocks k%4, top-left pixel index 64*(k/4) + 4*(k%4).
  - Pixel (y,x) of beat k lands at raster (4*(k/4)+y, 4*(k%4)+x).
- Counter `cnt[3:0]`:
  - Increments on each accepted beat.
  - Forced to 0 by `start`.
- `start` handling (any state):
  - Next state FILL, `cnt` set to 0, `out` cleared to 0, `err` cleared.
  - A beat offered in the same cycle is not accepted and does not set `err`.
- Transitions:
  - FILL, beat accepted with `cnt == 15`: go to FULL.
  - FULL: stay until the next `start`. `out` holds its value.
  - IDLE: stay until `start`.
- `err`: set when `in_valid & ~in_ready & ~start`. Cleared only by `start` or reset.
- Only the 16 bytes of the addressed sub-block change per accepted beat. All other bytes of `out` are held.
- No arithmetic; data is copied bit-exact.

## Timing
- Reset values: state IDLE, `cnt` 0, `out` 0, `done` 0, `busy` 0, `err` 0. `in_ready` is 0 because state is IDLE.
- `busy` is registered and high exactly while state == FILL. It rises on the edge after `start`.
- The first beat can be accepted in the cycle after `start`. Sustained throughput is one beat per cycle, so the minimum block takes 16 cycles after `start`.
- `done` is registered. It is high during the cycle immediately after the edge that accepts beat 15, and `out` is complete in that same cycle.
- Back-pressure: the source may insert idle cycles (`in_valid` = 0) at any point. `cnt` holds across them.
- `start` on the same cycle as the beat-15 handshake: `start` wins. The block restarts, `done` does not pulse, and `out` is cleared.
- `start` while FULL: `out` is cleared on the next edge. Downstream must capture `out` before issuing `start`.
- Reset mid-fill: all state returns to reset values immediately. No `done` pulse follows.
- `cnt` never wraps inside FILL, because the transition to FULL occurs at 15.

## Structure
- Shared package holds:
  - Pixel width and block-size constants.
  - The sub-block-to-raster offset function 64*(k/4) + 4*(k%4), shared with the 16x16 distortion slicing.
  - The state encoding.
- No sub-module is needed. The write path is a 16-way decoded byte-lane enable on the `out` register.

## Test plan
- Reset, then `start`, then beats k = 0..15 back-to-back with every byte = k -> `done` pulses 16 cycles after the first beat; byte at raster (r,c) = 4*(r/4) + c/4; `busy` is then 0 and `err` is 0.
- Beats with byte (y,x) of beat k = 16k + 4y + x, with `in_valid` toggled on alternate cycles -> `out` byte (4*(k/4)+y, 4*(k%4)+x) = 16k + 4y + x; `done` pulses once.
- `in_valid` = 1 in IDLE, then in FULL -> no acceptance and `out` unchanged; `err` = 1 until the next `start`.
- `start` asserted together with the beat-15 handshake -> no `done`; `out` = 0; `busy` = 1; next 16 beats complete normally.
- Assert `rst` after 7 beats -> all outputs 0 on the next sample; a subsequent `start` plus 16 beats gives a correct block.
- Full block, then `start` with no beats -> `out` reads all 0 one cycle after `start`; `done` stays 0.
